// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier driving an external adder via add_* ports.
// Optional build macro MULT_SIGNED_EN adds signed_mode for two's-complement operands.
module shift_add_multiplier #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
`ifdef MULT_SIGNED_EN
    input  logic           signed_mode,
`endif
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   add_x,
    output logic [N-1:0]   add_y,
    output logic           add_cin,
    input  logic [N:0]     add_result
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [N-1:0]  ZERO_N   = {N{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [N-1:0]     m_r, m_s;
    logic [N-1:0]     hi_r, hi_s;
    logic [N-1:0]     lo_r, lo_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [2*N-1:0]   product_r, product_s;
    logic [2*N-1:0]   prod_raw_s;
    logic [N-1:0]     add_x_s, add_y_s;
    logic             busy_r, done_r;

`ifdef MULT_SIGNED_EN
    logic neg_r, neg_s;

    function automatic logic [N-1:0] abs_n(input logic [N-1:0] v);
        // |v| as unsigned: the most-negative value maps onto 2^(N-1)
        if (v[N-1]) begin
            return ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + {{(2*N-1){1'b0}}, 1'b1};
    endfunction
`endif

    assign prod_raw_s = {add_result, lo_r[N-1:1]};

    // Next-state, datapath and adder-operand decode
    always_comb begin
        state_s   = state_r;
        m_s       = m_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        cnt_s     = cnt_r;
        product_s = product_r;
        add_x_s   = ZERO_N;
        add_y_s   = ZERO_N;
`ifdef MULT_SIGNED_EN
        neg_s     = neg_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    hi_s    = ZERO_N;
                    cnt_s   = {CW{1'b0}};
`ifdef MULT_SIGNED_EN
                    if (signed_mode) begin
                        m_s   = abs_n(A);
                        lo_s  = abs_n(B);
                        neg_s = A[N-1] ^ B[N-1];
                    end else begin
                        m_s   = A;
                        lo_s  = B;
                        neg_s = 1'b0;
                    end
`else
                    m_s  = A;
                    lo_s = B;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                add_x_s = hi_r;
                add_y_s = lo_r[0] ? m_r : ZERO_N;
                // Carry-out lands in HI's MSB; the sum's LSB shifts into LO
                hi_s    = add_result[N:1];
                lo_s    = {add_result[0], lo_r[N-1:1]};
                cnt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
`ifdef MULT_SIGNED_EN
                    product_s = neg_r ? neg_2n(prod_raw_s) : prod_raw_s;
`else
                    product_s = prod_raw_s;
`endif
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            m_r       <= ZERO_N;
            hi_r      <= ZERO_N;
            lo_r      <= ZERO_N;
            cnt_r     <= {CW{1'b0}};
            product_r <= {(2*N){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            m_r       <= m_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
            busy_r    <= (state_s == RUN);
            done_r    <= (state_s == DONE);
`ifdef MULT_SIGNED_EN
            neg_r     <= neg_s;
`endif
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign add_x   = add_x_s;
    assign add_y   = add_y_s;
    assign add_cin = 1'b0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: timeline/arithmetic model plus literal spot checks.
module tb_shift_add_multiplier;

    localparam int N = 64;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sm_v;
    logic [N-1:0]   A, B;
    logic           busy, done;
    logic [2*N-1:0] product;
    logic [N-1:0]   add_x, add_y;
    logic           add_cin;
    logic [N:0]     add_result;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    // External adder the block expects to see
    assign add_result = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_cin};

    shift_add_multiplier #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef MULT_SIGNED_EN
        .signed_mode(sm_v),
`endif
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .add_x      (add_x),
        .add_y      (add_y),
        .add_cin    (add_cin),
        .add_result (add_result)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: since = cycles since acceptance (0 = idle); product = |A|*|B| with optional sign
    int           since = 0;
    logic [N-1:0] ma, mb;
    bit           mneg;
    logic [127:0] exp_prod;

    always @(posedge clk) begin
        if (rst) begin
            since    <= 0;
            exp_prod <= 128'd0;
        end else if (since == 0) begin
            if (start) begin
                since <= 1;
                if (SIGNED_EN && sm_v) begin
                    ma   <= A[N-1] ? -A : A;
                    mb   <= B[N-1] ? -B : B;
                    mneg <= A[N-1] ^ B[N-1];
                end else begin
                    ma   <= A;
                    mb   <= B;
                    mneg <= 1'b0;
                end
            end
        end else if (since == N) begin
            since    <= N + 1;
            exp_prod <= mneg ? -({64'd0, ma} * {64'd0, mb}) : ({64'd0, ma} * {64'd0, mb});
        end else if (since == N + 1) begin
            since <= 0;
        end else begin
            since <= since + 1;
        end
    end

    // Every-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit           running = (since >= 1) && (since <= N);
            automatic int           it      = since - 1;
            automatic logic [127:0] part    = 128'd0;
            automatic logic [N-1:0] ey      = '0;
            if (running) begin
                part = ({64'd0, ma} * ({64'd0, mb} & ((128'd1 << it) - 128'd1))) >> it;
                ey   = mb[it] ? ma : '0;
            end
            chk("busy", 128'(busy), 128'(running));
            chk("done", 128'(done), 128'(since == N + 1));
            chk("product", product, exp_prod);
            chk("add_x", 128'(add_x), 128'(part[N-1:0]));
            chk("add_y", 128'(add_y), 128'(ey));
            chk("add_cin", 128'(add_cin), 128'd0);
        end
    end

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        @(negedge clk);
        A = a; B = b; sm_v = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b;
    endtask

    task automatic wait_done(input string nm, input logic [127:0] lit, input int exp_cyc);
        int cyc = 0;
        while (done !== 1'b1 && cyc < N + 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 128'(cyc), 128'(exp_cyc));
        chk({nm, "_lit"}, product, lit);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; sm_v = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_product", product, 128'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 3 x 5: add_y follows multiplier bits 1,0,1
        launch(64'd3, 64'd5, 1'b0);
        chk("y_it0", 128'(add_y), 128'd3);
        @(negedge clk);
        chk("y_it1", 128'(add_y), 128'd0);
        @(negedge clk);
        chk("y_it2", 128'(add_y), 128'd3);
        wait_done("m3x5", 128'd15, N - 2);

        // All ones: carry-out enters HI on iteration 1
        launch({N{1'b1}}, {N{1'b1}}, 1'b0);
        @(negedge clk);
        chk("carry_out", 128'(add_result[N]), 128'd1);
        @(negedge clk);
        chk("hi_after_carry", 128'(add_x), 128'hBFFF_FFFF_FFFF_FFFF);
        wait_done("ones", 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, N - 2);

        // Zero multiplier, then back-to-back start right after done
        launch(64'h1234, 64'd0, 1'b0);
        wait_done("zero", 128'd0, N);
        launch(64'd7, 64'd9, 1'b0);
        wait_done("m7x9", 128'd63, N);

        // Start pulsed mid-run is ignored
        launch(64'd2, 64'd3, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1; A = 64'd100; B = 64'd100;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_mid", 128'd6, N - 11);

        // Start held through DONE is accepted only once back in IDLE
        start = 1'b1; A = 64'd4; B = 64'd5;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("held", 128'd20, N);

        // Reset at RUN cycle 20 aborts with no done pulse
        launch(64'd11, 64'd13, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_product", product, 128'd0);
        seen = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 128'(seen), 128'd0);
        launch(64'd6, 64'd7, 1'b0);
        wait_done("m6x7", 128'd42, N);

        if (SIGNED_EN) begin
            launch(-64'sd3, 64'd5, 1'b1);
            wait_done("s_m3x5", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, N);
            launch(-64'sd3, -64'sd5, 1'b1);
            wait_done("s_m3xm5", 128'd15, N);
            launch({1'b1, {(N-1){1'b0}}}, {1'b1, {(N-1){1'b0}}}, 1'b1);
            wait_done("s_minmin", 128'h4000_0000_0000_0000_0000_0000_0000_0000, N);
        end
        launch({N{1'b1}}, 64'd2, 1'b0);
        wait_done("u_ones_x2", 128'h1_FFFF_FFFF_FFFF_FFFE, N);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
